// File: rtl/se_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package se_loader_pkg;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [63:0] DEF_BASE_ADDR  = 64'h0;
  localparam int unsigned DEF_MAX_WORDS  = 256;

  // CHECK is only reachable when the checksum option is compiled in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    CHECK   = 3'd4
  } loader_state_e;

endpackage

// File: rtl/se_byte_packer.sv
// Packs a stream of bytes little-endian into a 32-bit word.
// The first byte shifted in ends up in bits [7:0] once four bytes are in.
module se_byte_packer
  import se_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  // The incoming byte enters at the top, so the word is complete combinationally
  // on the cycle the fourth byte transfers.
  assign word      = {data, shreg};
  assign word_full = shift && (cnt == 2'(BYTES_PER_WORD - 1));

  // Shift register and byte counter; the counter wraps naturally after each word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= word[31:8];
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/se_instr_loader.sv
// Instruction-memory loader: byte stream in, 32-bit word writes out, and the
// core held in reset while a load is in progress.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module se_instr_loader
  import se_loader_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned       MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [15:0]       numWords_i,
  input  logic [7:0]        byte_i,
  input  logic              byteValid_i,
  output logic              byteReady_o,
  output logic [DATA_W-1:0] loadData_o,
  output logic [ADDR_W-1:0] loadAddr_o,
  output logic              wrEn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              coreRstN_o
);

  loader_state_e     state, state_nxt;
  logic [15:0]       num_words, idx;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q, err_q, core_rst_n_q;
  logic              byte_fire, start_ok, size_err, size_fail, last_word;
  logic              enter_done, chk_fail;
  logic [31:0]       pk_word;
  logic              pk_full;

  assign byte_fire  = byteValid_i && byteReady_o;
  assign start_ok   = (state == IDLE) && start_i;
  assign size_err   = 32'(numWords_i) > MAX_WORDS;
  assign size_fail  = start_ok && (numWords_i != 16'd0) && size_err;
  assign last_word  = (idx + 16'd1) == num_words;
  assign enter_done = (state_nxt == DONE) && (state != DONE);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  assign chk_fail = (state == CHECK) && byte_fire && (byte_i != chk_q);
`else
  assign chk_fail = 1'b0;
`endif

  se_byte_packer u_packer (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .clear     (start_ok),
    .shift     (byte_fire && (state == COLLECT)),
    .data      (byte_i),
    .word      (pk_word),
    .word_full (pk_full)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a zero-length or oversized load goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (numWords_i == 16'd0 || size_err) state_nxt = DONE;
          else                                 state_nxt = COLLECT;
        end
      end
      COLLECT: if (pk_full) state_nxt = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (byte_fire) state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake, write strobe and busy decoded from the state.
  always_comb begin
    byteReady_o = 1'b0;
    wrEn_o      = 1'b0;
    busy_o      = 1'b0;
    case (state)
      COLLECT: begin byteReady_o = 1'b1; busy_o = 1'b1; end
      WRITE:   begin wrEn_o      = 1'b1; busy_o = 1'b1; end
`ifdef LOADER_CHECKSUM_EN
      CHECK:   begin byteReady_o = 1'b1; busy_o = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Load bookkeeping, write port registers and sticky status flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      num_words    <= '0;
      idx          <= '0;
      data_q       <= '0;
      addr_q       <= BASE_ADDR;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      if (start_ok) begin
        num_words    <= numWords_i;
        idx          <= '0;
        done_q       <= 1'b0;
        err_q        <= 1'b0;
        core_rst_n_q <= 1'b0;
      end
      if ((state == COLLECT) && pk_full) begin
        data_q <= DATA_W'(pk_word);
        addr_q <= BASE_ADDR + (ADDR_W'(idx) << 2);
      end
      if (state == WRITE) idx <= idx + 16'd1;
      if (enter_done) begin
        done_q       <= 1'b1;
        core_rst_n_q <= !chk_fail;
      end
      if (size_fail || chk_fail) err_q <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every payload byte, compared against the trailing byte.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                             chk_q <= '0;
    else if (start_ok)                        chk_q <= '0;
    else if ((state == COLLECT) && byte_fire) chk_q <= chk_q ^ byte_i;
  end
`endif

  assign loadData_o = data_q;
  assign loadAddr_o = addr_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign coreRstN_o = core_rst_n_q;

endmodule

// File: tb/tb_se_instr_loader.sv
// Scoreboard bench for se_instr_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares them as wrEn_o pulses.
module tb_se_instr_loader;

  localparam int          ADDR_W = 64;
  localparam int          DATA_W = 32;
  localparam logic [63:0] BASE   = 64'h0;
  localparam int          MAXW   = 256;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [15:0]       numWords_i = '0;
  logic [7:0]        byte_i = '0;
  logic              byteValid_i = 1'b0;
  logic              byteReady_o;
  logic [DATA_W-1:0] loadData_o;
  logic [ADDR_W-1:0] loadAddr_o;
  logic              wrEn_o, busy_o, done_o, err_o, coreRstN_o;

  wr_t sb_q[$];
  int  n_checks = 0;
  int  n_fails  = 0;
  int  n_writes = 0;
  bit  loading  = 1'b0;

  se_instr_loader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start_i),
    .numWords_i (numWords_i),
    .byte_i     (byte_i),
    .byteValid_i(byteValid_i),
    .byteReady_o(byteReady_o),
    .loadData_o (loadData_o),
    .loadAddr_o (loadAddr_o),
    .wrEn_o     (wrEn_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .coreRstN_o (coreRstN_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop expected writes and watch busy/core-reset relationship.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n && wrEn_o) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_write: addr %h data %h, no write expected", loadAddr_o, loadData_o);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", loadAddr_o, e.addr);
        check("wr_data", 64'(loadData_o), 64'(e.data));
      end
    end
    if (rst_n && loading) check("busy_during_load", 64'(busy_o), 64'd1);
    if (rst_n && busy_o)  check("core_held_while_busy", 64'(coreRstN_o), 64'd0);
  end

  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    bit ok;
    int gaps;
    gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    byteValid_i = 1'b0;
    repeat (gaps) tick();
    byte_i      = b;
    byteValid_i = 1'b1;
    ok          = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (byteReady_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
    tick();
    byteValid_i = 1'b0;
    byte_i      = 8'($urandom);
  endtask

  task automatic checkOutput(input bit exp_err, input bit exp_core, input int exp_writes);
    check("done", 64'(done_o), 64'd1);
    check("err", 64'(err_o), 64'(exp_err));
    check("core_rst_n", 64'(coreRstN_o), 64'(exp_core));
    check("busy_after", 64'(busy_o), 64'd0);
    check("write_count", 64'(n_writes), 64'(exp_writes));
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    tick();
    check("done_held", 64'(done_o), 64'd1);
  endtask

  // Reference model: computes expected writes and final status, then drives the load.
  task automatic applyStimulus(input int n, input byte_q_t bytes, input int gap_mode,
                               input bit bad_chk, input int inject_at);
    wr_t         e;
    logic [7:0]  chk;
    logic [31:0] w;
    bit          exp_err, exp_core, payload;
    int          exp_writes, budget;
    bit          seen;

    payload    = (n > 0) && (n <= MAXW);
    exp_err    = (n > MAXW);
    exp_core   = 1'b1;
    exp_writes = payload ? n : 0;
    chk        = 8'h00;
    if (payload) begin
      for (int i = 0; i < n; i++) begin
        w = 0;
        for (int k = 0; k < 4; k++) begin
          w   = w + 32'(bytes[4*i+k]) * (32'd1 << (8*k));
          chk = chk ^ bytes[4*i+k];
        end
        e.addr = BASE + 64'(4 * i);
        e.data = w;
        sb_q.push_back(e);
      end
`ifdef LOADER_CHECKSUM_EN
      if (bad_chk) begin
        exp_err  = 1'b1;
        exp_core = 1'b0;
      end
`endif
    end

    n_writes   = 0;
    start_i    = 1'b1;
    numWords_i = 16'(n);
    tick();
    start_i    = 1'b0;
    numWords_i = 16'($urandom);

    if (payload) begin
      loading = 1'b1;
      for (int i = 0; i < 4*n; i++) begin
        send_byte(bytes[i], gap_mode);
        if (i == inject_at) begin
          start_i    = 1'b1;
          numWords_i = 16'd5;
          tick();
          start_i    = 1'b0;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_chk ? (chk ^ 8'h01) : chk, gap_mode);
`else
      if (bad_chk) $display("[TB] checksum option not built; bad checksum flag ignored");
`endif
      loading = 1'b0;
    end

    budget = payload ? 20 : 2;
    seen   = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_within_budget", 64'(seen), 64'd1);
    checkOutput(exp_err, exp_core, exp_writes);
  endtask

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    byte_q_t q;
    int      n;

    // Reset values while reset is asserted.
    #1;
    check("rst_ready", 64'(byteReady_o), 64'd0);
    check("rst_data", 64'(loadData_o), 64'd0);
    check("rst_addr", loadAddr_o, BASE);
    check("rst_wren", 64'(wrEn_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_core", 64'(coreRstN_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_core_held", 64'(coreRstN_o), 64'd0);

    $display("[TB] two-word load, continuous stream");
    q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    applyStimulus(2, q, 0, 1'b0, -1);

    $display("[TB] two-word load, valid toggling");
    applyStimulus(2, q, 1, 1'b0, -1);

    $display("[TB] zero-length and oversized loads");
    applyStimulus(0, q, 0, 1'b0, -1);
    applyStimulus(MAXW + 1, q, 0, 1'b0, -1);

    $display("[TB] start pulsed during collection");
    applyStimulus(2, q, 1, 1'b0, 2);

    $display("[TB] reset in the middle of a word");
    start_i    = 1'b1;
    numWords_i = 16'd2;
    tick();
    start_i    = 1'b0;
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(byteReady_o), 64'd0);
    check("mid_rst_data", 64'(loadData_o), 64'd0);
    check("mid_rst_addr", loadAddr_o, BASE);
    check("mid_rst_wren", 64'(wrEn_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    check("mid_rst_err", 64'(err_o), 64'd0);
    check("mid_rst_core", 64'(coreRstN_o), 64'd0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    q = '{8'h37, 8'h05, 8'h00, 8'h80};
    applyStimulus(1, q, 0, 1'b0, -1);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum match and mismatch");
    q = '{8'h01, 8'h02, 8'h04, 8'h08};
    applyStimulus(1, q, 0, 1'b0, -1);
    applyStimulus(1, q, 0, 1'b1, -1);
`endif

    $display("[TB] randomized loads");
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 6));
      q.delete();
      for (int i = 0; i < 4*n; i++) q.push_back(8'($urandom));
      applyStimulus(n, q, int'($urandom_range(0, 2)), 1'b0, -1);
    end

    $display("[TB] full-capacity load");
    q.delete();
    for (int i = 0; i < 4*MAXW; i++) q.push_back(8'($urandom));
    applyStimulus(MAXW, q, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
